// File: rtl/alu_pkg.sv
// Opcode encodings and a packed view of one ALU result, shared by the core and the top.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NEG = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_ROL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;
  localparam logic [3:0] OP_SHL = 4'b1111;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       v;
  } alu_res_t;

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational ALU datapath: result, zero, carry/borrow/shift-out and signed overflow.
module alu_8bit_core
  import alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [3:0] sel_i,
  output alu_res_t   res_o
);

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] neg8;
  logic [7:0] r;
  logic       c;
  logic       v;

  assign sum9  = {1'b0, a_i} + {1'b0, b_i};
  // Bit 8 of the 9-bit difference is set exactly when a_i < b_i unsigned.
  assign diff9 = {1'b0, a_i} - {1'b0, b_i};
  assign neg8  = (~a_i) + 8'd1;

  always_comb begin
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    unique case (sel_i)
      OP_ADD: begin
        r = sum9[7:0];
        c = sum9[8];
        v = (a_i[7] == b_i[7]) && (sum9[7] != a_i[7]);
      end
      OP_SUB: begin
        r = diff9[7:0];
        c = diff9[8];
        v = (a_i[7] != b_i[7]) && (diff9[7] != a_i[7]);
      end
      OP_NEG: begin
        r = neg8;
        c = (a_i == 8'h00);
        v = (a_i == 8'h80);
      end
      OP_AND: r = a_i & b_i;
      OP_XOR: r = a_i ^ b_i;
      OP_OR:  r = a_i | b_i;
      OP_NOT: r = ~a_i;
      OP_ROR: begin
        r = {a_i[0], a_i[7:1]};
        c = a_i[0];
      end
      OP_ROL: begin
        r = {a_i[6:0], a_i[7]};
        c = a_i[7];
      end
      OP_SHR: begin
        r = {1'b0, a_i[7:1]};
        c = a_i[0];
      end
      OP_SHL: begin
        r = {a_i[6:0], 1'b0};
        c = a_i[7];
      end
      default: begin
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
  end

  assign res_o = '{r: r, z: (r == 8'h00), c: c, v: v};

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: operands sampled on one rising edge, result and flags valid after it.
// No handshake: a new operation is accepted every cycle and the output register always updates.
module alu_8bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] sel,
  output logic [7:0] F,
  output logic       z,
  output logic       c_out,
  output logic       over_flow
);

  alu_res_t res_d;
  alu_res_t res_q;

  alu_8bit_core u_core (
    .a_i   (A),
    .b_i   (B),
    .sel_i (sel),
    .res_o (res_d)
  );

  // Reset wins over the operation sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign F         = res_q.r;
  assign z         = res_q.z;
  assign c_out     = res_q.c;
  assign over_flow = res_q.v;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed table-driven bench for alu_8bit, plus hand-written reset and back-to-back sequences.
module tb_alu_8bit;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NEG = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_ROL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;
  localparam logic [3:0] OP_SHL = 4'b1111;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] f;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] sel;
  logic [7:0] F;
  logic       z;
  logic       c_out;
  logic       over_flow;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  alu_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .F         (F),
    .z         (z),
    .c_out     (c_out),
    .over_flow (over_flow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic add_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [7:0] f, input logic zz,
                         input logic cc, input logic vv);
    vec_t t;
    t.name = name; t.a = a; t.b = b; t.sel = s;
    t.f = f; t.z = zz; t.c = cc; t.v = vv;
    vecs.push_back(t);
  endtask

  // driver: apply inputs away from the rising edge and queue the expected result
  task automatic drive(input string name, input logic r, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] s, input logic [10:0] exp);
    @(negedge clk);
    rst = r; A = a; B = b; sel = s;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // scoreboard: one cycle after sampling, compare against the head of the queue
  task automatic check_next();
    logic [10:0] exp;
    logic [10:0] act;
    string       nm;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    act = {F, z, c_out, over_flow};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got F=%h z=%b c=%b v=%b, expected F=%h z=%b c=%b v=%b",
               nm, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input string name, input logic r, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] s, input logic [7:0] f,
                       input logic zz, input logic cc, input logic vv);
    drive(name, r, a, b, s, {f, zz, cc, vv});
    check_next();
  endtask

  initial begin
    add_vec("add_3_2",   8'h03, 8'h02, OP_ADD, 8'h05, 1'b0, 1'b0, 1'b0);
    add_vec("sub_3_2",   8'h03, 8'h02, OP_SUB, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec("neg_3",     8'h03, 8'h02, OP_NEG, 8'hFD, 1'b0, 1'b0, 1'b0);
    add_vec("and_3_2",   8'h03, 8'h02, OP_AND, 8'h02, 1'b0, 1'b0, 1'b0);
    add_vec("xor_3_2",   8'h03, 8'h02, OP_XOR, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec("or_3_2",    8'h03, 8'h02, OP_OR,  8'h03, 1'b0, 1'b0, 1'b0);
    add_vec("not_3",     8'h03, 8'h02, OP_NOT, 8'hFC, 1'b0, 1'b0, 1'b0);
    add_vec("ror_3",     8'h03, 8'h02, OP_ROR, 8'h81, 1'b0, 1'b1, 1'b0);
    add_vec("rol_3",     8'h03, 8'h02, OP_ROL, 8'h06, 1'b0, 1'b0, 1'b0);
    add_vec("shr_3",     8'h03, 8'h02, OP_SHR, 8'h01, 1'b0, 1'b1, 1'b0);
    add_vec("shl_3",     8'h03, 8'h02, OP_SHL, 8'h06, 1'b0, 1'b0, 1'b0);
    add_vec("sub_3_3",   8'h03, 8'h03, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("sub_2_3",   8'h02, 8'h03, OP_SUB, 8'hFF, 1'b0, 1'b1, 1'b0);
    add_vec("sub_80_01", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1);
    add_vec("add_7f_01", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
    add_vec("add_ff_01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0);
    add_vec("add_80_80", 8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b1);
    add_vec("neg_00",    8'h00, 8'h55, OP_NEG, 8'h00, 1'b1, 1'b1, 1'b0);
    add_vec("neg_80",    8'h80, 8'h55, OP_NEG, 8'h80, 1'b0, 1'b0, 1'b1);
    add_vec("xor_eq",    8'hAA, 8'hAA, OP_XOR, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("not_ff",    8'hFF, 8'h00, OP_NOT, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("and_f0_3c", 8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0, 1'b0, 1'b0);
    add_vec("or_f0_0f",  8'hF0, 8'h0F, OP_OR,  8'hFF, 1'b0, 1'b0, 1'b0);
    add_vec("ror_80",    8'h80, 8'hFF, OP_ROR, 8'h40, 1'b0, 1'b0, 1'b0);
    add_vec("rol_80",    8'h80, 8'hFF, OP_ROL, 8'h01, 1'b0, 1'b1, 1'b0);
    add_vec("shr_01",    8'h01, 8'hFF, OP_SHR, 8'h00, 1'b1, 1'b1, 1'b0);
    add_vec("shl_80",    8'h80, 8'hFF, OP_SHL, 8'h00, 1'b1, 1'b1, 1'b0);
    add_vec("shl_c3",    8'hC3, 8'h00, OP_SHL, 8'h86, 1'b0, 1'b1, 1'b0);
    add_vec("unused_2",  8'h03, 8'h02, 4'b0010, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("unused_4",  8'hFF, 8'hFF, 4'b0100, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("unused_6",  8'h7F, 8'h01, 4'b0110, 8'h00, 1'b1, 1'b0, 1'b0);
    add_vec("unused_7",  8'h80, 8'h80, 4'b0111, 8'h00, 1'b1, 1'b0, 1'b0);

    rst = 1'b1; A = 8'h03; B = 8'h02; sel = OP_ADD;

    // reset held for two edges with a live ADD on the inputs
    apply("reset_1", 1'b1, 8'h03, 8'h02, OP_ADD, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("reset_2", 1'b1, 8'h03, 8'h02, OP_ADD, 8'h00, 1'b0, 1'b0, 1'b0);

    // table, applied back to back one operation per cycle
    foreach (vecs[i])
      apply(vecs[i].name, 1'b0, vecs[i].a, vecs[i].b, vecs[i].sel,
            vecs[i].f, vecs[i].z, vecs[i].c, vecs[i].v);

    // mid-stream reset discards the ADD sampled alongside it
    apply("stream_add_1", 1'b0, 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
    apply("stream_add_2", 1'b0, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0);
    apply("stream_add_3", 1'b0, 8'h10, 8'h20, OP_ADD, 8'h30, 1'b0, 1'b0, 1'b0);
    apply("mid_reset",    1'b1, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b0, 1'b0, 1'b0);
    apply("after_reset",  1'b0, 8'h03, 8'h02, OP_ADD, 8'h05, 1'b0, 1'b0, 1'b0);
    apply("unused_5",     1'b0, 8'h03, 8'h02, 4'b0101, 8'h00, 1'b1, 1'b0, 1'b0);
    // a non-zero result after the unused opcode shows the register keeps updating
    apply("post_unused",  1'b0, 8'h03, 8'h02, OP_NOT, 8'hFC, 1'b0, 1'b0, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
